// File: rtl/uart_io_ctrl.sv
// UART I/O controller: receive holding register, status flags, input-port mux select,
// transmit-load pulse and interrupt. Optional macro UART_TX_IRQ_EN adds a TXRDY-rise interrupt.
module uart_io_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] port_id,
    input  logic        read_strobe,
    input  logic        write_strobe,
    input  logic [15:0] out_port,
    input  logic        interrupt_ack,
    input  logic        rx_done,
    input  logic [7:0]  rx_byte,
    input  logic        rx_ferr,
    input  logic        rx_perr,
    input  logic        tx_rdy,
    output logic        mux_sel,
    output logic [7:0]  data_byte,
    output logic [7:0]  status_byte,
    output logic        tx_load,
    output logic [7:0]  tx_data,
    output logic        interrupt
);

    localparam logic [15:0] RX_PORT     = 16'h0000;
    localparam logic [15:0] STATUS_PORT = 16'h0001;
    localparam logic [15:0] TX_PORT     = 16'h0000;

    logic rxrdy, ovr, ferr, perr, txrdy_q;
    logic data_rd, stat_rd, tx_wr, tx_go, tx_drop, ovr_set, irq_set;

    // Only the low byte of the write data reaches the transmitter.
    logic unused_out_hi;
    assign unused_out_hi = &{1'b0, out_port[15:8]};

    assign mux_sel     = (port_id == STATUS_PORT);
    assign status_byte = {3'b000, perr, ferr, ovr, txrdy_q, rxrdy};

    // NOTE: pure continuous assigns keep the decode free of latches and of any
    // dependence on process ordering.
    assign data_rd = read_strobe  && (port_id == RX_PORT);
    assign stat_rd = read_strobe  && (port_id == STATUS_PORT);
    assign tx_wr   = write_strobe && (port_id == TX_PORT);
    // A write landing while a load pulse is still out counts as busy, so tx_load never doubles up.
    assign tx_go   = tx_wr && txrdy_q && !tx_load;
    assign tx_drop = tx_wr && !tx_go;
    assign ovr_set = (rx_done && rxrdy && !data_rd) || tx_drop;

`ifdef UART_TX_IRQ_EN
    logic txrdy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) txrdy_d <= 1'b0;
        else       txrdy_d <= txrdy_q;
    end

    assign irq_set = rx_done || (txrdy_q && !txrdy_d);
`else
    assign irq_set = rx_done;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, which is what makes read-clear-at-closing-edge work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_byte <= 8'h00;
            rxrdy     <= 1'b0;
            ferr      <= 1'b0;
            perr      <= 1'b0;
            ovr       <= 1'b0;
            txrdy_q   <= 1'b0;
            tx_load   <= 1'b0;
            tx_data   <= 8'h00;
            interrupt <= 1'b0;
        end else begin
            txrdy_q <= tx_rdy;
            tx_load <= tx_go;
            if (tx_go) tx_data <= out_port[7:0];

            if (rx_done) begin
                data_byte <= rx_byte;
                rxrdy     <= 1'b1;
                ferr      <= rx_ferr;
                perr      <= rx_perr;
            end else begin
                if (data_rd) rxrdy <= 1'b0;
                if (stat_rd) begin
                    ferr <= 1'b0;
                    perr <= 1'b0;
                end
            end

            // A set always beats a status-read clear; a receive in the read cycle also keeps OVR.
            if (ovr_set)                  ovr <= 1'b1;
            else if (stat_rd && !rx_done) ovr <= 1'b0;

            if (irq_set)            interrupt <= 1'b1;
            else if (interrupt_ack) interrupt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Self-checking bench for uart_io_ctrl: table of per-cycle vectors plus a reset-mid-transfer sequence.
module tb_uart_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] port_id;
    logic        read_strobe, write_strobe;
    logic [15:0] out_port;
    logic        interrupt_ack, rx_done;
    logic [7:0]  rx_byte;
    logic        rx_ferr, rx_perr, tx_rdy;
    logic        mux_sel;
    logic [7:0]  data_byte, status_byte;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        interrupt;

    int checks = 0;
    int errors = 0;

`ifdef UART_TX_IRQ_EN
    localparam bit TXIRQ = 1'b1;
`else
    localparam bit TXIRQ = 1'b0;
`endif

    uart_io_ctrl dut (
        .clk(clk), .reset(reset), .port_id(port_id),
        .read_strobe(read_strobe), .write_strobe(write_strobe), .out_port(out_port),
        .interrupt_ack(interrupt_ack), .rx_done(rx_done), .rx_byte(rx_byte),
        .rx_ferr(rx_ferr), .rx_perr(rx_perr), .tx_rdy(tx_rdy),
        .mux_sel(mux_sel), .data_byte(data_byte), .status_byte(status_byte),
        .tx_load(tx_load), .tx_data(tx_data), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pid;
        logic        rd;
        logic        wr;
        logic [15:0] op;
        logic        ack;
        logic        rxd;
        logic [7:0]  rxb;
        logic        fe;
        logic        pe;
        logic        txr;
        logic        e_mux;
        logic [7:0]  e_data;
        logic [7:0]  e_st;
        logic        e_load;
        logic [7:0]  e_txd;
        logic        e_int;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        port_id = v.pid; read_strobe = v.rd; write_strobe = v.wr; out_port = v.op;
        interrupt_ack = v.ack; rx_done = v.rxd; rx_byte = v.rxb;
        rx_ferr = v.fe; rx_perr = v.pe; tx_rdy = v.txr;
    endtask

    task automatic idle(input logic [15:0] pid, input logic txr);
        port_id = pid; read_strobe = 0; write_strobe = 0; out_port = 16'h0000;
        interrupt_ack = 0; rx_done = 0; rx_byte = 8'h00; rx_ferr = 0; rx_perr = 0; tx_rdy = txr;
    endtask

    initial begin
        //          pid      rd wr op        ack rxd rxb    fe pe txr  mux data   st     ld txd    int
        vecs[0]  = '{16'h0001,0,0,16'h0000, 0, 0, 8'h00, 0, 0, 0,   1, 8'h00, 8'h00, 0, 8'h00, 0};
        vecs[1]  = '{16'h0000,0,0,16'h0000, 0, 1, 8'hA5, 0, 0, 0,   0, 8'hA5, 8'h01, 0, 8'h00, 1};
        vecs[2]  = '{16'h0000,1,0,16'h0000, 0, 0, 8'h00, 0, 0, 0,   0, 8'hA5, 8'h00, 0, 8'h00, 1};
        vecs[3]  = '{16'h0000,0,0,16'h0000, 1, 0, 8'h00, 0, 0, 0,   0, 8'hA5, 8'h00, 0, 8'h00, 0};
        vecs[4]  = '{16'h0000,0,0,16'h0000, 0, 1, 8'h11, 0, 0, 0,   0, 8'h11, 8'h01, 0, 8'h00, 1};
        vecs[5]  = '{16'h0000,0,0,16'h0000, 0, 1, 8'h22, 0, 0, 0,   0, 8'h22, 8'h05, 0, 8'h00, 1};
        vecs[6]  = '{16'h0001,1,0,16'h0000, 0, 0, 8'h00, 0, 0, 0,   1, 8'h22, 8'h01, 0, 8'h00, 1};
        vecs[7]  = '{16'h0000,1,0,16'h0000, 0, 1, 8'h33, 0, 0, 0,   0, 8'h33, 8'h01, 0, 8'h00, 1};
        vecs[8]  = '{16'h0000,0,0,16'h0000, 1, 1, 8'h44, 1, 1, 0,   0, 8'h44, 8'h1D, 0, 8'h00, 1};
        vecs[9]  = '{16'h0001,1,0,16'h0000, 0, 1, 8'h55, 0, 1, 0,   1, 8'h55, 8'h15, 0, 8'h00, 1};
        vecs[10] = '{16'h0001,1,0,16'h0000, 0, 0, 8'h00, 0, 0, 0,   1, 8'h55, 8'h01, 0, 8'h00, 1};
        vecs[11] = '{16'h0000,1,0,16'h0000, 1, 0, 8'h00, 0, 0, 0,   0, 8'h55, 8'h00, 0, 8'h00, 0};
        vecs[12] = '{16'h0000,0,0,16'h0000, 0, 0, 8'h00, 0, 0, 1,   0, 8'h55, 8'h02, 0, 8'h00, 0};
        vecs[13] = '{16'h0000,0,1,16'h0048, 0, 0, 8'h00, 0, 0, 1,   0, 8'h55, 8'h02, 1, 8'h48, TXIRQ};
        vecs[14] = '{16'h0000,0,0,16'h0000, 0, 0, 8'h00, 0, 0, 0,   0, 8'h55, 8'h00, 0, 8'h48, TXIRQ};
        vecs[15] = '{16'h0000,0,1,16'h0048, 1, 0, 8'h00, 0, 0, 0,   0, 8'h55, 8'h04, 0, 8'h48, 0};
        vecs[16] = '{16'h0001,1,0,16'h0000, 0, 0, 8'h00, 0, 0, 0,   1, 8'h55, 8'h00, 0, 8'h48, 0};

        reset = 1'b1;
        idle(16'h0001, 1'b0);
        #1;
        check("mux_sel_in_reset", {7'd0, mux_sel}, 8'h01);
        repeat (2) @(negedge clk);
        check("rst_data",   data_byte,   8'h00);
        check("rst_status", status_byte, 8'h00);
        check("rst_load",   {7'd0, tx_load},   8'h00);
        check("rst_txdata", tx_data,     8'h00);
        check("rst_int",    {7'd0, interrupt}, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_mux", i), {7'd0, mux_sel}, {7'd0, vecs[i].e_mux});
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_data", i),   data_byte,          vecs[i].e_data);
            check($sformatf("v%0d_status", i), status_byte,        vecs[i].e_st);
            check($sformatf("v%0d_load", i),   {7'd0, tx_load},    {7'd0, vecs[i].e_load});
            check($sformatf("v%0d_txdata", i), tx_data,            vecs[i].e_txd);
            check($sformatf("v%0d_int", i),    {7'd0, interrupt},  {7'd0, vecs[i].e_int});
        end

        // Reset in the middle of a pending transmit load and a fresh receive.
        idle(16'h0000, 1'b1);
        @(negedge clk);
        idle(16'h0000, 1'b1);
        write_strobe = 1'b1; out_port = 16'h005A;
        rx_done = 1'b1; rx_byte = 8'hAA;
        @(posedge clk);
        #1;
        check("mid_load_before", {7'd0, tx_load}, 8'h01);
        check("mid_data_before", data_byte,       8'hAA);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_load",   {7'd0, tx_load},   8'h00);
        check("mid_rst_txdata", tx_data,           8'h00);
        check("mid_rst_data",   data_byte,         8'h00);
        check("mid_rst_status", status_byte,       8'h00);
        check("mid_rst_int",    {7'd0, interrupt}, 8'h00);
        check("mid_rst_mux0",   {7'd0, mux_sel},   8'h00);
        port_id = 16'h0001;
        #1;
        check("mid_rst_mux1",   {7'd0, mux_sel},   8'h01);
        @(negedge clk);
        idle(16'h0001, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_load",   {7'd0, tx_load},   8'h00);
        check("post_rst_status", status_byte,       8'h00);
        check("post_rst_int",    {7'd0, interrupt}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
